// File: rtl/fir_pkg.sv
// Shared types, default widths and the output saturation helper for the TDM FIR engine.
// Combinational only; no latency or flow control.
package fir_pkg;

    localparam int DW_DEF   = 16;
    localparam int CW_DEF   = 16;
    localparam int FRAC_DEF = 14;
    localparam int ACCW_DEF = 40;

    localparam logic signed [CW_DEF-1:0] Q14_ONE = 16'sd16384;

    typedef enum logic [1:0] {CLEAR, IDLE, MAC, DONE} state_e;

    typedef struct packed {
        logic                     sat;
        logic signed [DW_DEF-1:0] data;
    } sat_out_t;

    localparam logic signed [ACCW_DEF-1:0] S_MAX = ACCW_DEF'((2 ** (DW_DEF - 1)) - 1);
    localparam logic signed [ACCW_DEF-1:0] S_MIN = ACCW_DEF'(-(2 ** (DW_DEF - 1)));

    // Arithmetic shift floors toward -inf before the clamp.
    function automatic sat_out_t sat_shift(input logic signed [ACCW_DEF-1:0] acc,
                                           input int frac = FRAC_DEF);
        logic signed [ACCW_DEF-1:0] s;
        sat_out_t r;
        s = acc >>> frac;
        if (s > S_MAX) begin
            r.sat  = 1'b1;
            r.data = S_MAX[DW_DEF-1:0];
        end else if (s < S_MIN) begin
            r.sat  = 1'b1;
            r.data = S_MIN[DW_DEF-1:0];
        end else begin
            r.sat  = 1'b0;
            r.data = s[DW_DEF-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Shared multiply-accumulate: registered 16x16 product feeding a full-precision accumulator.
// Two-cycle issue-to-acc latency; no backpressure, clr_i wins over en_i.
module fir_mac_unit
    import fir_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int CW   = CW_DEF,
    parameter int ACCW = ACCW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_i,
    input  logic                   en_i,
    input  logic signed [DW-1:0]   x_i,
    input  logic signed [CW-1:0]   c_i,
    output logic signed [ACCW-1:0] acc_o
);

    logic signed [DW+CW-1:0] p_q;
    logic                    p_vld_q;
    logic signed [ACCW-1:0]  acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q     <= '0;
            p_vld_q <= 1'b0;
            acc_q   <= '0;
        end else if (clr_i) begin
            p_vld_q <= 1'b0;
            acc_q   <= '0;
        end else begin
            p_vld_q <= en_i;
            if (en_i) begin
                p_q <= x_i * c_i;
            end
            if (p_vld_q) begin
                acc_q <= acc_q + ACCW'(p_q);
            end
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/fir_tdm_scheduler.sv
// Time-multiplexed N-tap FIR: one shared MAC walks all taps per sample; out_valid N+1 edges after the input handshake.
// in_ready only in IDLE (state-derived); the result is held in DONE until out_ready.
module fir_tdm_scheduler
    import fir_pkg::*;
#(
    parameter int N    = 123,
    parameter int DW   = DW_DEF,
    parameter int CW   = CW_DEF,
    parameter int FRAC = FRAC_DEF,
    parameter int AW   = 7,
    parameter int ACCW = ACCW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic                 out_sat,
    input  logic                 coef_we,
    input  logic [AW-1:0]        coef_addr,
    input  logic signed [CW-1:0] coef_wdata,
    output logic                 busy
);

    localparam logic [AW:0]   N_K      = (AW + 1)'(N);
    localparam logic [AW:0]   K_LAST   = (AW + 1)'(N - 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(N - 1);

    state_e                  state_q, state_d;
    logic [AW:0]             k_q, k_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic                    hs;
    logic                    mac_en;
    logic                    coef_ok;
    logic [AW:0]             ptr_ext;
    logic [AW-1:0]           rd_ptr;
    logic signed [DW-1:0]    x_sel;
    logic signed [CW-1:0]    c_sel;
    logic signed [ACCW-1:0]  acc;
    sat_out_t                sat_res;

    logic signed [DW-1:0] x_mem    [N];
    logic signed [CW-1:0] coef_mem [N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= CLEAR;
            k_q      <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // k doubles as the clear index in CLEAR and runs one past the last tap in MAC to drain the product register.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        wr_ptr_d  = wr_ptr_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        hs        = 1'b0;
        mac_en    = 1'b0;
        case (state_q)
            CLEAR: begin
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = IDLE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    hs      = 1'b1;
                    k_d     = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                mac_en = (k_q < N_K);
                if (k_q == N_K) begin
                    state_d  = DONE;
                    wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    assign ptr_ext = {1'b0, wr_ptr_q};
    assign coef_ok = coef_we && (state_q == IDLE) && !hs && ({1'b0, coef_addr} < N_K);

    always_comb begin
        rd_ptr = '0;
        x_sel  = '0;
        c_sel  = '0;
        if (mac_en) begin
            rd_ptr = (ptr_ext >= k_q) ? AW'(ptr_ext - k_q) : AW'(ptr_ext + N_K - k_q);
            x_sel  = x_mem[rd_ptr];
            c_sel  = coef_mem[k_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            x_mem[k_q[AW-1:0]] <= '0;
        end else if (hs) begin
            x_mem[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (coef_ok) begin
            coef_mem[coef_addr] <= coef_wdata;
        end
    end

    fir_mac_unit #(
        .DW   (DW),
        .CW   (CW),
        .ACCW (ACCW)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clr_i (hs),
        .en_i  (mac_en),
        .x_i   (x_sel),
        .c_i   (c_sel),
        .acc_o (acc)
    );

    assign sat_res  = sat_shift(acc, FRAC);
    assign out_data = sat_res.data;
    assign out_sat  = sat_res.sat;

endmodule
